// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32I opcodes, ALU operation encodings, immediate
// formats and helpers used by the decode logic.
package cpu_pkg;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // 4-bit ALU operation encodings carried into execute
   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // Immediate formats; NONE yields a zero immediate
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   // Sign-extended immediate for the given format
   function automatic logic [31:0] build_imm(input logic [31:0] instr, input imm_fmt_e fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

   // ALU op from funct3; instr[30] selects SRA and (register form only) SUB
   function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt,
                                              input logic allow_sub);
      alu_op_e op;
      case (funct3)
         3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder: control flags, ALU op, immediate and
// which source registers the instruction actually reads.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output logic [4:0]  rd_addr,
   output logic [3:0]  alu_op,
   output logic        rd_we,
   output logic        alu_src_imm,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        branch,
   output logic        jump,
   output logic        illegal,
   output logic        use_rs1,
   output logic        use_rs2
);

   logic [6:0] opcode;
   imm_fmt_e   fmt;
   alu_op_e    alu_sel;
   logic       writes_rd;

   assign opcode  = instr[6:0];
   assign rd_addr = instr[11:7];

   // Opcode-driven control decode; unknown opcodes fall to illegal with no side effects
   always_comb begin
      fmt         = IMM_NONE;
      alu_sel     = ALU_ADD;
      writes_rd   = 1'b0;
      alu_src_imm = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
      illegal     = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      case (opcode)
         OPC_LUI: begin
            fmt = IMM_U; alu_sel = ALU_PASSB; writes_rd = 1'b1; alu_src_imm = 1'b1;
         end
         OPC_AUIPC: begin
            fmt = IMM_U; writes_rd = 1'b1; alu_src_imm = 1'b1;
         end
         OPC_JAL: begin
            fmt = IMM_J; writes_rd = 1'b1; jump = 1'b1; alu_src_imm = 1'b1;
         end
         OPC_JALR: begin
            fmt = IMM_I; writes_rd = 1'b1; jump = 1'b1; alu_src_imm = 1'b1; use_rs1 = 1'b1;
         end
         OPC_BRANCH: begin
            fmt = IMM_B; alu_sel = ALU_SUB; branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_LOAD: begin
            fmt = IMM_I; writes_rd = 1'b1; alu_src_imm = 1'b1; mem_rd = 1'b1; use_rs1 = 1'b1;
         end
         OPC_STORE: begin
            fmt = IMM_S; alu_src_imm = 1'b1; mem_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_OP_IMM: begin
            fmt = IMM_I; writes_rd = 1'b1; alu_src_imm = 1'b1; use_rs1 = 1'b1;
            alu_sel = alu_from_funct(instr[14:12], instr[30], 1'b0);
         end
         OPC_OP: begin
            writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            alu_sel = alu_from_funct(instr[14:12], instr[30], 1'b1);
         end
         default: illegal = 1'b1;
      endcase
   end

   assign imm    = build_imm(instr, fmt);
   assign alu_op = alu_sel;
   assign rd_we  = writes_rd && (rd_addr != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes the fetched instruction, applies writeback
// bypass to the operands, stalls on load-use hazards and holds the ID/EX register.
module decode_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_val,
   output logic [31:0] ex_rs2_val,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rd_addr,
   output logic [3:0]  ex_alu_op,
   output logic        ex_rd_we,
   output logic        ex_alu_src_imm,
   output logic        ex_mem_rd,
   output logic        ex_mem_wr,
   output logic        ex_branch,
   output logic        ex_jump,
   output logic        ex_illegal
);

   logic [31:0] dec_imm;
   logic [4:0]  dec_rd_addr;
   logic [3:0]  dec_alu_op;
   logic        dec_rd_we, dec_alu_src_imm, dec_mem_rd, dec_mem_wr;
   logic        dec_branch, dec_jump, dec_illegal, dec_use_rs1, dec_use_rs2;
   logic [31:0] rs1_val, rs2_val;
   logic        hazard, transfer;

   instr_decoder u_decoder (
      .instr       (if_instr),
      .imm         (dec_imm),
      .rd_addr     (dec_rd_addr),
      .alu_op      (dec_alu_op),
      .rd_we       (dec_rd_we),
      .alu_src_imm (dec_alu_src_imm),
      .mem_rd      (dec_mem_rd),
      .mem_wr      (dec_mem_wr),
      .branch      (dec_branch),
      .jump        (dec_jump),
      .illegal     (dec_illegal),
      .use_rs1     (dec_use_rs1),
      .use_rs2     (dec_use_rs2)
   );

   assign rs1_addr = if_instr[19:15];
   assign rs2_addr = if_instr[24:20];

   // A same-cycle writeback to a source register wins over the stale file read
   assign rs1_val = (wb_we && (wb_addr != 5'd0) && (wb_addr == rs1_addr)) ? wb_data : rs1_data;
   assign rs2_val = (wb_we && (wb_addr != 5'd0) && (wb_addr == rs2_addr)) ? wb_data : rs2_data;

   // Load in EX whose result feeds a source this instruction actually reads
   assign hazard = ex_valid && ex_mem_rd && (ex_rd_addr != 5'd0) &&
                   ((dec_use_rs1 && (rs1_addr == ex_rd_addr)) ||
                    (dec_use_rs2 && (rs2_addr == ex_rd_addr)));

   assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
   assign transfer = if_valid && if_ready;

   // ID/EX register: flush beats transfer, transfer beats drain, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid       <= 1'b0;
         ex_pc          <= 32'd0;
         ex_rs1_val     <= 32'd0;
         ex_rs2_val     <= 32'd0;
         ex_imm         <= 32'd0;
         ex_rd_addr     <= 5'd0;
         ex_alu_op      <= 4'd0;
         ex_rd_we       <= 1'b0;
         ex_alu_src_imm <= 1'b0;
         ex_mem_rd      <= 1'b0;
         ex_mem_wr      <= 1'b0;
         ex_branch      <= 1'b0;
         ex_jump        <= 1'b0;
         ex_illegal     <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (transfer) begin
         ex_valid       <= 1'b1;
         ex_pc          <= if_pc;
         ex_rs1_val     <= rs1_val;
         ex_rs2_val     <= rs2_val;
         ex_imm         <= dec_imm;
         ex_rd_addr     <= dec_rd_addr;
         ex_alu_op      <= dec_alu_op;
         ex_rd_we       <= dec_rd_we;
         ex_alu_src_imm <= dec_alu_src_imm;
         ex_mem_rd      <= dec_mem_rd;
         ex_mem_wr      <= dec_mem_wr;
         ex_branch      <= dec_branch;
         ex_jump        <= dec_jump;
         ex_illegal     <= dec_illegal;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage with a transaction-level
// reference model of the ID/EX slot and a behavioural register file.
module tb_decode_stage;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                          A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                          A_OR = 4'd8, A_AND = 4'd9, A_PASSB = 4'd10;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rd_addr;
   logic [3:0]  ex_alu_op;
   logic        ex_rd_we, ex_alu_src_imm, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op), .ex_rd_we(ex_rd_we),
      .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
   );

   // Behavioural register file, x0 hard-wired to zero
   logic [31:0] regs [32];
   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

   typedef struct packed {
      logic [31:0] pc, rs1_val, rs2_val, imm;
      logic [4:0]  rd;
      logic [3:0]  alu;
      logic        rd_we, src_imm, mem_rd, mem_wr, branch, jump, illegal, use1, use2;
   } dec_t;

   int   errors = 0;
   int   checks = 0;
   logic m_valid;
   dec_t m_slot;
   logic [6:0] opc_tab [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
      end
   endtask

   // Immediates computed numerically from the field values
   function automatic logic [31:0] sext(input int v, input int bits);
      int r;
      r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
      return 32'(r);
   endfunction

   function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input logic is_op);
      case (f3)
         3'd0: return (is_op && b30) ? A_SUB : A_ADD;
         3'd1: return A_SLL;
         3'd2: return A_SLT;
         3'd3: return A_SLTU;
         3'd4: return A_XOR;
         3'd5: return b30 ? A_SRA : A_SRL;
         3'd6: return A_OR;
         default: return A_AND;
      endcase
   endfunction

   function automatic dec_t ref_decode(input logic [31:0] ins);
      dec_t d;
      int   i_v, s_v, b_v, j_v;
      d = '0;
      i_v = int'(ins[31:20]);
      s_v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
      b_v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      j_v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) + int'(ins[20]) * (1 << 11)
            + int'(ins[30:21]) * 2;
      d.rd = ins[11:7];
      case (ins[6:0])
         7'h37: begin d.imm = ins & 32'hFFFFF000; d.alu = A_PASSB; d.rd_we = 1; d.src_imm = 1; end
         7'h17: begin d.imm = ins & 32'hFFFFF000; d.rd_we = 1; d.src_imm = 1; end
         7'h6F: begin d.imm = sext(j_v, 21); d.rd_we = 1; d.jump = 1; d.src_imm = 1; end
         7'h67: begin d.imm = sext(i_v, 12); d.rd_we = 1; d.jump = 1; d.src_imm = 1; d.use1 = 1; end
         7'h63: begin d.imm = sext(b_v, 13); d.alu = A_SUB; d.branch = 1; d.use1 = 1; d.use2 = 1; end
         7'h03: begin d.imm = sext(i_v, 12); d.rd_we = 1; d.src_imm = 1; d.mem_rd = 1; d.use1 = 1; end
         7'h23: begin d.imm = sext(s_v, 12); d.src_imm = 1; d.mem_wr = 1; d.use1 = 1; d.use2 = 1; end
         7'h13: begin
            d.imm = sext(i_v, 12); d.rd_we = 1; d.src_imm = 1; d.use1 = 1;
            d.alu = ref_alu(ins[14:12], ins[30], 1'b0);
         end
         7'h33: begin
            d.rd_we = 1; d.use1 = 1; d.use2 = 1;
            d.alu = ref_alu(ins[14:12], ins[30], 1'b1);
         end
         default: d.illegal = 1;
      endcase
      if (d.rd == 5'd0) d.rd_we = 0;
      return d;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] a);
      if (wb_we && wb_addr != 5'd0 && wb_addr == a) return wb_data;
      return (a == 5'd0) ? 32'd0 : regs[a];
   endfunction

   task automatic check_ex(input string tag);
      chk(tag, "ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid) begin
         chk(tag, "ex_pc", ex_pc, m_slot.pc);
         chk(tag, "ex_rs1_val", ex_rs1_val, m_slot.rs1_val);
         chk(tag, "ex_rs2_val", ex_rs2_val, m_slot.rs2_val);
         chk(tag, "ex_imm", ex_imm, m_slot.imm);
         chk(tag, "ex_rd_addr", 32'(ex_rd_addr), 32'(m_slot.rd));
         chk(tag, "ex_alu_op", 32'(ex_alu_op), 32'(m_slot.alu));
         chk(tag, "ex_rd_we", 32'(ex_rd_we), 32'(m_slot.rd_we));
         chk(tag, "ex_alu_src_imm", 32'(ex_alu_src_imm), 32'(m_slot.src_imm));
         chk(tag, "ex_mem_rd", 32'(ex_mem_rd), 32'(m_slot.mem_rd));
         chk(tag, "ex_mem_wr", 32'(ex_mem_wr), 32'(m_slot.mem_wr));
         chk(tag, "ex_branch", 32'(ex_branch), 32'(m_slot.branch));
         chk(tag, "ex_jump", 32'(ex_jump), 32'(m_slot.jump));
         chk(tag, "ex_illegal", 32'(ex_illegal), 32'(m_slot.illegal));
      end
   endtask

   task automatic check_reset(input string tag);
      chk(tag, "ex_valid", 32'(ex_valid), 32'd0);
      chk(tag, "ex_pc", ex_pc, 32'd0);
      chk(tag, "ex_rs1_val", ex_rs1_val, 32'd0);
      chk(tag, "ex_rs2_val", ex_rs2_val, 32'd0);
      chk(tag, "ex_imm", ex_imm, 32'd0);
      chk(tag, "ex_rd_addr", 32'(ex_rd_addr), 32'd0);
      chk(tag, "ex_alu_op", 32'(ex_alu_op), 32'd0);
      chk(tag, "ex_flags", 32'({ex_rd_we, ex_alu_src_imm, ex_mem_rd, ex_mem_wr,
                                ex_branch, ex_jump, ex_illegal}), 32'd0);
   endtask

   // One clock: inputs are set at the falling edge by the caller
   task automatic step(input string tag);
      dec_t d;
      logic hz, rdy, acc;
      logic [4:0] a1, a2;
      #1;
      d  = ref_decode(if_instr);
      a1 = if_instr[19:15];
      a2 = if_instr[24:20];
      hz = m_valid && m_slot.mem_rd && m_slot.rd != 5'd0 &&
           ((d.use1 && a1 == m_slot.rd) || (d.use2 && a2 == m_slot.rd));
      rdy = (!m_valid || ex_ready) && !hz && !flush;
      acc = 1'b0;
      chk(tag, "if_ready", 32'(if_ready), 32'(rdy));
      chk(tag, "rs_addr", 32'({rs1_addr, rs2_addr}), 32'({a1, a2}));
      if (flush) m_valid = 1'b0;
      else if (if_valid && rdy) begin
         d.pc = if_pc; d.rs1_val = operand(a1); d.rs2_val = operand(a2);
         m_slot = d; m_valid = 1'b1; acc = 1'b1;
      end else if (ex_ready) m_valid = 1'b0;
      @(posedge clk);
      #1;
      if (wb_we && wb_addr != 5'd0) regs[wb_addr] = wb_data;
      check_ex(tag);
      $display("%s: pc=%h instr=%h accepted=%0b ex_valid=%0b", tag, if_pc, if_instr, acc, ex_valid);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r, held_pc;
      rst = 1; if_valid = 0; if_instr = 32'h0000_0013; if_pc = 0; wb_we = 0; wb_addr = 0;
      wb_data = 0; flush = 0; ex_ready = 1; m_valid = 0; m_slot = '0;
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
      #3;
      check_reset("reset_initial");
      @(negedge clk); @(negedge clk);
      rst = 0;
      step("idle_after_reset");
      #1 chk("idle_after_reset", "if_ready_const", 32'(if_ready), 32'd1);

      // ADDI x5,x1,-4 with x1=10
      regs[1] = 32'd10; if_valid = 1; if_instr = 32'hFFC08293; if_pc = 32'h100;
      step("addi");
      chk("addi", "imm_const", ex_imm, 32'hFFFFFFFC);
      chk("addi", "rs1_const", ex_rs1_val, 32'd10);
      chk("addi", "rd_const", 32'(ex_rd_addr), 32'd5);
      chk("addi", "alu_const", 32'(ex_alu_op), 32'(A_ADD));
      chk("addi", "src_imm_const", 32'(ex_alu_src_imm), 32'd1);

      // ADD x3,x1,x2 with a writeback to x1 in the same cycle
      regs[1] = 32'd0; regs[2] = 32'd7; wb_we = 1; wb_addr = 5'd1; wb_data = 32'h55;
      if_instr = 32'h002081B3; if_pc = 32'h104;
      step("bypass");
      chk("bypass", "rs1_const", ex_rs1_val, 32'h55);
      chk("bypass", "rs2_const", ex_rs2_val, 32'd7);
      wb_we = 0;

      // LW x4,0(x2) then ADD x6,x4,x4: one bubble
      if_instr = 32'h00012203; if_pc = 32'h108;
      step("lw_x4");
      if_instr = 32'h00420333; if_pc = 32'h10C;
      step("lu_stall");
      chk("lu_stall", "bubble", 32'(ex_valid), 32'd0);
      step("lu_issue");
      chk("lu_issue", "valid_const", 32'(ex_valid), 32'd1);
      chk("lu_issue", "rd_const", 32'(ex_rd_addr), 32'd6);

      // LW x0 then ADD x6,x0,x0: no bubble
      if_instr = 32'h00012003; if_pc = 32'h110;
      step("lw_x0");
      if_instr = 32'h00000333; if_pc = 32'h114;
      step("no_stall");
      chk("no_stall", "valid_const", 32'(ex_valid), 32'd1);
      chk("no_stall", "pc_const", ex_pc, 32'h114);

      // Backpressure for three cycles
      if_instr = 32'h00A00093; if_pc = 32'h200;
      step("bp_load");
      held_pc = 32'h200;
      ex_ready = 0; if_instr = 32'h00100113; if_pc = 32'h204;
      for (int k = 0; k < 3; k++) begin
         step("bp_hold");
         chk("bp_hold", "pc_stable", ex_pc, held_pc);
         #1 chk("bp_hold", "if_ready_low", 32'(if_ready), 32'd0);
      end

      // Flush with a pending instruction
      ex_ready = 1; flush = 1; if_pc = 32'h300;
      step("flush");
      chk("flush", "valid_const", 32'(ex_valid), 32'd0);
      flush = 0; if_valid = 0;
      step("after_flush");
      chk("after_flush", "not_accepted", 32'(ex_valid), 32'd0);

      // Illegal opcode 0x7F with rd=x7
      if_valid = 1; if_instr = 32'h000003FF; if_pc = 32'h400;
      step("illegal");
      chk("illegal", "illegal_const", 32'(ex_illegal), 32'd1);
      chk("illegal", "rd_we_const", 32'(ex_rd_we), 32'd0);
      chk("illegal", "mem_wr_const", 32'(ex_mem_wr), 32'd0);

      // Async reset while holding
      if_instr = 32'h00012483; if_pc = 32'h500;
      step("pre_rst_load");
      ex_ready = 0;
      step("pre_rst_hold");
      #2 rst = 1;
      #1 check_reset("reset_mid_hold");
      m_valid = 0;
      @(negedge clk);
      rst = 0; if_valid = 0; ex_ready = 1;
      step("post_rst_idle");
      if_valid = 1; if_instr = 32'h00500513; if_pc = 32'h504;
      step("post_rst_accept");

      // Randomized traffic with small register indices to provoke hazards/bypass
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         r[19:15] = 5'($urandom_range(0, 7));
         r[24:20] = 5'($urandom_range(0, 7));
         r[11:7]  = 5'($urandom_range(0, 7));
         r[6:0]   = opc_tab[$urandom_range(0, 9)];
         if_instr = r;
         if_pc    = $urandom & 32'hFFFFFFFC;
         if_valid = ($urandom_range(0, 3) != 0);
         ex_ready = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         wb_we    = $urandom_range(0, 1) != 0;
         wb_addr  = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
